// File: rtl/alu_exec_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_pkg
// Shared definitions for the multi-cycle ALU execution unit:
//   - ALUOp class codes (same encoding as the existing ALU control decode)
//   - R-type / shift-immediate function codes
//   - internal operation enum produced by alu_exec_decode
//   - FSM state enum used by alu_exec_unit
// Optional feature macro: ALU_EXEC_MUL_EN (see alu_exec_unit).
// ---------------------------------------------------------------------------
package alu_exec_pkg;

    // ALUOp class codes
    localparam logic [2:0] ALUOP_RTYPE  = 3'd0;
    localparam logic [2:0] ALUOP_SHIFTI = 3'd1;
    localparam logic [2:0] ALUOP_ADD    = 3'd2;
    localparam logic [2:0] ALUOP_SUB    = 3'd3;
    localparam logic [2:0] ALUOP_SL     = 3'd4;
    localparam logic [2:0] ALUOP_SRL    = 3'd5;
    localparam logic [2:0] ALUOP_SRA    = 3'd6;
    localparam logic [2:0] ALUOP_SLT    = 3'd7;

    // Function field codes (R-type and shift-immediate classes)
    localparam logic [2:0] FUNK_ADD = 3'd0;
    localparam logic [2:0] FUNK_SUB = 3'd1;
    localparam logic [2:0] FUNK_OR  = 3'd2;
    localparam logic [2:0] FUNK_AND = 3'd3;
    localparam logic [2:0] FUNK_SL  = 3'd4;
    localparam logic [2:0] FUNK_SRL = 3'd5;
    localparam logic [2:0] FUNK_SRA = 3'd6;
    localparam logic [2:0] FUNK_SLT = 3'd7;
    localparam logic [2:0] FUNK_MUL = 3'd0;  // only meaningful under ALUOP_SHIFTI

    typedef enum logic [3:0] {
        OP_AND,
        OP_OR,
        OP_ADD,
        OP_SUB,
        OP_SL,
        OP_SRL,
        OP_SRA,
        OP_SLT,
        OP_MUL,
        OP_ILL
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL,
        ST_DONE
    } state_e;

    function automatic logic is_shift_op(input op_e op);
        return (op == OP_SL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_decode.sv
// ---------------------------------------------------------------------------
// alu_exec_decode
// Purely combinational (alu_op, funk) -> internal op decode.
// Ports:
//   alu_op  in  3  ALUOp class code
//   funk    in  3  function field
//   op      out    internal op (OP_ILL for undefined combinations)
// With ALU_EXEC_MUL_EN defined, alu_op 1 / funk 0 decodes to OP_MUL;
// otherwise that combination is illegal.
// ---------------------------------------------------------------------------
module alu_exec_decode
    import alu_exec_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [2:0] funk,
    output op_e        op
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statements can leave it unassigned (no latch).
    always_comb begin
        op = OP_ILL;
        case (alu_op)
            ALUOP_RTYPE: begin
                case (funk)
                    FUNK_ADD: op = OP_ADD;
                    FUNK_SUB: op = OP_SUB;
                    FUNK_OR:  op = OP_OR;
                    FUNK_AND: op = OP_AND;
                    FUNK_SL:  op = OP_SL;
                    FUNK_SRL: op = OP_SRL;
                    FUNK_SRA: op = OP_SRA;
                    default:  op = OP_SLT;
                endcase
            end
            ALUOP_SHIFTI: begin
                case (funk)
                    FUNK_SL:  op = OP_SL;
                    FUNK_SRL: op = OP_SRL;
                    FUNK_SRA: op = OP_SRA;
`ifdef ALU_EXEC_MUL_EN
                    FUNK_MUL: op = OP_MUL;
`endif
                    default:  op = OP_ILL;
                endcase
            end
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_SL:  op = OP_SL;
            ALUOP_SRL: op = OP_SRL;
            ALUOP_SRA: op = OP_SRA;
            default:   op = OP_SLT;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Multi-cycle ALU execution unit. Single-cycle ops (and/or/add/sub/slt and
// illegal) finish in one cycle; shifts move one bit per cycle (latency
// 1 + shamt); optional multiply is a WIDTH-step shift-add (latency WIDTH+1).
// Optional feature macro: ALU_EXEC_MUL_EN (enables alu_op 1 / funk 0 multiply).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 request strobe, sampled only while ready=1
//   alu_op[2:0], funk[2:0] operation select
//   a, b [WIDTH-1:0]      operands; b[SHAMT_W-1:0] is the shift amount
//   ready                 idle, next start accepted
//   done                  one-cycle completion pulse
//   result, zero, err     registered outputs, held until next completion
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [2:0]       funk,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    // One extra bit so the counter can hold WIDTH for the multiply.
    localparam int CNT_W = SHAMT_W + 1;

    state_e             state_q,  state_d;
    op_e                op_q,     op_d;
    logic [WIDTH-1:0]   work_q,   work_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q,   zero_d;
    logic               err_q,    err_d;
`ifdef ALU_EXEC_MUL_EN
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]   acc_next;
`endif

    op_e                dec_op;
    logic [WIDTH-1:0]   quick_res;
    logic [WIDTH-1:0]   shift_step;
    logic [SHAMT_W-1:0] shamt;

    alu_exec_decode u_decode (
        .alu_op (alu_op),
        .funk   (funk),
        .op     (dec_op)
    );

    assign shamt = b[SHAMT_W-1:0];

    // Single-cycle results, computed straight from the inputs on the accepting edge.
    always_comb begin
        quick_res = '0;
        case (dec_op)
            OP_AND:  quick_res = a & b;
            OP_OR:   quick_res = a | b;
            OP_ADD:  quick_res = a + b;
            OP_SUB:  quick_res = a - b;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: quick_res = '0;
        endcase
    end

    // One-bit shift of the working register in the captured direction.
    always_comb begin
        case (op_q)
            OP_SL:   shift_step = {work_q[WIDTH-2:0], 1'b0};
            OP_SRA:  shift_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shift_step = {1'b0, work_q[WIDTH-1:1]};
        endcase
    end

`ifdef ALU_EXEC_MUL_EN
    // Shift-add step: work_q is the multiplicand shifted left each cycle.
    assign acc_next = mplier_q[0] ? (acc_q + work_q) : acc_q;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
`ifdef ALU_EXEC_MUL_EN
        mplier_d = mplier_q;
        acc_d    = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = dec_op;
                    if (is_shift_op(dec_op)) begin
                        if (shamt == '0) begin
                            state_d  = ST_DONE;
                            result_d = a;
                            zero_d   = (a == '0);
                            err_d    = 1'b0;
                        end else begin
                            state_d = ST_SHIFT;
                            work_d  = a;
                            cnt_d   = {1'b0, shamt};
                        end
                    end
`ifdef ALU_EXEC_MUL_EN
                    else if (dec_op == OP_MUL) begin
                        state_d  = ST_MUL;
                        work_d   = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(WIDTH);
                    end
`endif
                    else begin
                        // Illegal decode falls through with quick_res = 0.
                        state_d  = ST_DONE;
                        result_d = quick_res;
                        zero_d   = (quick_res == '0);
                        err_d    = (dec_op == OP_ILL);
                    end
                end
            end
            ST_SHIFT: begin
                work_d = shift_step;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_DONE;
                    result_d = shift_step;
                    zero_d   = (shift_step == '0);
                    err_d    = 1'b0;
                end
            end
`ifdef ALU_EXEC_MUL_EN
            ST_MUL: begin
                acc_d    = acc_next;
                work_d   = {work_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_DONE;
                    result_d = acc_next;
                    zero_d   = (acc_next == '0);
                    err_d    = 1'b0;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_AND;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            mplier_q <= '0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
`ifdef ALU_EXEC_MUL_EN
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign zero   = zero_q;
    assign err    = err_q;

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (>= 4).
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), shift-amount field width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request strobe; sampled only when ready=1.
REQ-006 alu_op  input  3  ALUOp class code, same encoding as the existing ALU control decode.
REQ-007 funk  input  3  function field for R-type and shift-immediate classes.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B; b[SHAMT_W-1:0] is the shift amount for shifts.
REQ-010 ready  output  1  unit idle, start will be accepted.
REQ-011 done  output  1  one-cycle pulse, result/zero/err valid and held until next accepted start.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  result == 0, registered with result.
REQ-014 err  output  1  undefined alu_op/funk combination for the accepted request.

Function
REQ-015 Decode SHALL be: alu_op 0 -> funk 0 add, 1 sub, 2 or, 3 and, 4 sl, 5 srl, 6 sra, 7 slt; alu_op 1 -> funk 4 sl, 5 srl, 6 sra, others illegal; alu_op 2..7 -> add, sub, sl, srl, sra, slt.
REQ-016 Operands, alu_op and funk SHALL be captured on the accepting edge; later input changes have no effect.
REQ-017 FSM states SHALL be IDLE, SHIFT, MUL, DONE; ready=1 only in IDLE.
REQ-018 IDLE + start with and/or/add/sub/slt/illegal -> DONE; result computed that edge; done=1 the following cycle (latency 1).
REQ-019 IDLE + start with shift -> SHIFT with shift counter = shamt; one bit per cycle, counter decrements; counter 0 -> DONE; latency = 1 + shamt (shamt 0 -> latency 1).
REQ-020 sl fills zeros; srl fills zeros; sra replicates a[WIDTH-1].
REQ-021 add/sub SHALL wrap modulo 2^WIDTH; slt SHALL compare signed, result 1 or 0 zero-extended.
REQ-022 Illegal decode SHALL give result 0, zero 1, err 1; legal ops give err 0.
REQ-023 DONE lasts one cycle, then IDLE; done is asserted only in DONE.
REQ-024 start while ready=0 SHALL be ignored and not queued.
REQ-025 start in DONE cycle SHALL be ignored (ready=0); next accept earliest in following IDLE cycle.

Reset
REQ-026 reset SHALL force IDLE, ready 1, done 0, result 0, zero 1, err 0, counters 0, asynchronously.
REQ-027 Reset mid-operation SHALL abort without a done pulse; first post-reset start behaves as from power-up.

Configuration
REQ-028 Macro ALU_EXEC_MUL_EN defined: alu_op 1 funk 0 SHALL be multiply (unsigned shift-add, low WIDTH bits), state MUL, latency WIDTH+1.
REQ-029 ALU_EXEC_MUL_EN undefined: alu_op 1 funk 0 SHALL be illegal per REQ-022; no MUL state or multiplier logic present.

Structure
REQ-030 Package alu_exec_pkg SHALL hold ALUOp class constants, internal op enum (AND, OR, ADD, SUB, SL, SRL, SRA, SLT, MUL, ILL) and FSM state enum.
REQ-031 Sub-module alu_exec_decode SHALL be purely combinational: (alu_op, funk) -> internal op.

Verification (WIDTH=16)
REQ-032 a=0x0005, b=0x0003, alu_op 0, funk 0 -> done 1 cycle after accept, result 0x0008, zero 0, err 0.
REQ-033 a=0x8000, b=0x0004, alu_op 6 -> done 5 cycles after accept, result 0xF800; start pulsed mid-shift ignored.
REQ-034 a=0xFFFF, b=0x0001, alu_op 7 -> result 0x0001; a=0x0001, b=0xFFFF -> result 0x0000, zero 1.
REQ-035 alu_op 1, funk 2 -> done after 1 cycle, err 1, result 0x0000, zero 1.
REQ-036 srl with b=0x000A, reset asserted 3 cycles after accept -> ready 1 immediately, no done pulse, result 0x0000.
REQ-037 With ALU_EXEC_MUL_EN: a=0x0012, b=0x0003, alu_op 1, funk 0 -> done 17 cycles after accept, result 0x0036; without macro -> err 1.
